port_inserter: RTL and testbench

//  Egress counterpart of the ingress port parser: rewrites the L4 source and/or destination port
//  of outbound TCP/UDP packets with per-AXIS-ID configured values. Incrementally fixes the L4

---
 rtl/port_inserter.sv | 162 ++++++++++++++++
 tb/tb_port_inserter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/port_inserter.sv
// port_inserter: egress L4 port rewriter. Replaces the TCP/UDP source and/or
// destination port with per-ID configured values and patches the L4 checksum
// incrementally (RFC 1624). One output register stage, 1 beat/cycle.
module port_inserter #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 4,
  parameter int AXIS_DEST_WIDTH   = 0,
  parameter int TUSER_WIDTH       = 16,
  parameter int MAX_PACKET_LENGTH = 1522,
  localparam int ID_W   = (AXIS_ID_WIDTH   == 0) ? 1 : AXIS_ID_WIDTH,
  localparam int DEST_W = (AXIS_DEST_WIDTH == 0) ? 1 : AXIS_DEST_WIDTH,
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [TUSER_WIDTH-1:0]    axis_in_tuser,
  input  logic [ID_W-1:0]           axis_in_tid,
  input  logic [DEST_W-1:0]         axis_in_tdest,
  input  logic [KEEP_W-1:0]         axis_in_tkeep,
  input  logic                      axis_in_tlast,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
  output logic [TUSER_WIDTH-1:0]    axis_out_tuser,
  output logic [ID_W-1:0]           axis_out_tid,
  output logic [DEST_W-1:0]         axis_out_tdest,
  output logic [KEEP_W-1:0]         axis_out_tkeep,
  output logic                      axis_out_tlast,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  output logic [ID_W-1:0]           port_config_sel,
  input  logic [33:0]               port_config_regs
);

  localparam int          KW      = $clog2(KEEP_W);
  localparam logic [16:0] BYTES17 = 17'(KEEP_W);
  localparam logic [16:0] MAX17   = 17'(MAX_PACKET_LENGTH);

  // Packet context; the L4 metadata and tid are only trusted on the SOP beat.
  logic            sop;
  logic [15:0]     pos;
  logic [15:0]     acc;   // ones-complement sum, end-around carry folded on every add
  logic [ID_W-1:0] tid_q;
  logic            l4v_q, tcp_q;
  logic [6:0]      off_q;

  logic                      accept;
  logic                      beat_l4v, beat_tcp;
  logic [15:0]               s_pos, d_pos, c_pos, s_dif, d_dif, c_dif;
  logic [KW-1:0]             s_k, d_k, c_k;
  logic                      s_hit, d_hit, c_hit;
  logic [15:0]               old_s, old_d, old_c, c_new, acc_n, pos_n;
  logic [16:0]               pos_inc;
  logic [AXIS_BUS_WIDTH-1:0] data_n;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // A 16-bit field is in this beat when both of its bytes are.
  function automatic logic hit(input logic [15:0] p, input logic [15:0] base);
    return ({1'b0, p} >= {1'b0, base}) && ({1'b0, p} + 17'd1 < {1'b0, base} + BYTES17);
  endfunction

  function automatic logic [15:0] get_word(input logic [AXIS_BUS_WIDTH-1:0] d, input logic [KW-1:0] k);
    return {d[int'(k)*8 +: 8], d[(int'(k)+1)*8 +: 8]};
  endfunction

  function automatic logic [AXIS_BUS_WIDTH-1:0] put_word(input logic [AXIS_BUS_WIDTH-1:0] d,
                                                          input logic [KW-1:0] k, input logic [15:0] w);
    d[int'(k)*8 +: 8]     = w[15:8];
    d[(int'(k)+1)*8 +: 8] = w[7:0];
    return d;
  endfunction

  assign accept          = axis_in_tvalid & axis_in_tready;
  assign axis_in_tready  = ~axis_out_tvalid | axis_out_tready;
  assign port_config_sel = sop ? axis_in_tid : tid_q;

  // Locate S/D/C in the current beat, rewrite them and fold the deltas into the checksum.
  always_comb begin
    beat_l4v = sop ? axis_in_tuser[8] : l4v_q;
    beat_tcp = sop ? axis_in_tuser[7] : tcp_q;
    s_pos    = {9'd0, (sop ? axis_in_tuser[6:0] : off_q)};
    d_pos    = s_pos + 16'd2;
    c_pos    = s_pos + (beat_tcp ? 16'd16 : 16'd6);
    s_dif    = s_pos - pos;
    d_dif    = d_pos - pos;
    c_dif    = c_pos - pos;
    s_k      = s_dif[KW-1:0];
    d_k      = d_dif[KW-1:0];
    c_k      = c_dif[KW-1:0];
    s_hit    = beat_l4v && hit(s_pos, pos);
    d_hit    = beat_l4v && hit(d_pos, pos);
    c_hit    = beat_l4v && hit(c_pos, pos);
    old_s    = get_word(axis_in_tdata, s_k);
    old_d    = get_word(axis_in_tdata, d_k);
    old_c    = get_word(axis_in_tdata, c_k);
    data_n   = axis_in_tdata;
    acc_n    = sop ? 16'h0000 : acc;
    c_new    = old_c;
    if (s_hit && port_config_regs[33]) begin
      acc_n  = oc_add(oc_add(acc_n, ~old_s), port_config_regs[31:16]);
      data_n = put_word(data_n, s_k, port_config_regs[31:16]);
    end
    if (d_hit && port_config_regs[32]) begin
      acc_n  = oc_add(oc_add(acc_n, ~old_d), port_config_regs[15:0]);
      data_n = put_word(data_n, d_k, port_config_regs[15:0]);
    end
    // A zero UDP checksum means "no checksum" and must stay zero.
    if (c_hit && (port_config_regs[33] || port_config_regs[32]) && !(!beat_tcp && old_c == 16'h0000)) begin
      c_new = ~oc_add(~old_c, acc_n);
      if (!beat_tcp && c_new == 16'h0000) c_new = 16'hFFFF;
      data_n = put_word(data_n, c_k, c_new);
    end
    pos_inc = {1'b0, pos} + BYTES17;
    pos_n   = (pos_inc >= MAX17) ? MAX17[15:0] : pos_inc[15:0];
  end

  // Output register and packet context; reset drops any in-flight beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      axis_out_tdata  <= '0;
      axis_out_tuser  <= '0;
      axis_out_tid    <= '0;
      axis_out_tdest  <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tvalid <= 1'b0;
      sop             <= 1'b1;
      pos             <= '0;
      acc             <= '0;
      tid_q           <= '0;
      l4v_q           <= 1'b0;
      tcp_q           <= 1'b0;
      off_q           <= '0;
    end else if (accept) begin
      axis_out_tdata  <= data_n;
      axis_out_tuser  <= axis_in_tuser;
      axis_out_tid    <= axis_in_tid;
      axis_out_tdest  <= axis_in_tdest;
      axis_out_tkeep  <= axis_in_tkeep;
      axis_out_tlast  <= axis_in_tlast;
      axis_out_tvalid <= 1'b1;
      acc             <= acc_n;
      if (sop) begin
        tid_q <= axis_in_tid;
        l4v_q <= axis_in_tuser[8];
        tcp_q <= axis_in_tuser[7];
        off_q <= axis_in_tuser[6:0];
      end
      sop <= axis_in_tlast;
      pos <= axis_in_tlast ? 16'd0 : pos_n;
    end else if (axis_out_tready) begin
      axis_out_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_port_inserter.sv
// tb_port_inserter: table of packet cases with hand-computed expected port and
// checksum words, a scoreboard of expected output beats, and directed sequences
// for reset mid-packet and a one-beat 512-bit TCP packet.
`timescale 1ns/1ps
module tb_port_inserter;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [63:0] in_data = '0;
  logic [15:0] in_user = '0;
  logic [3:0]  in_tid = '0;
  logic [1:0]  in_dest = '0;
  logic [7:0]  in_keep = '0;
  logic        in_last = 1'b0, in_valid = 1'b0, in_ready;
  logic [63:0] out_data;
  logic [15:0] out_user;
  logic [3:0]  out_tid;
  logic [1:0]  out_dest;
  logic [7:0]  out_keep;
  logic        out_last, out_valid, out_ready = 1'b1;
  logic [3:0]  sel;
  logic [33:0] cfg_regs;

  logic [511:0] b_in_data = '0, b_out_data;
  logic [15:0]  b_in_user = '0, b_out_user;
  logic [3:0]   b_in_tid = '0, b_out_tid, b_sel;
  logic [0:0]   b_in_dest = '0, b_out_dest;
  logic [63:0]  b_in_keep = '0, b_out_keep;
  logic         b_in_last = 1'b0, b_in_valid = 1'b0, b_in_ready;
  logic         b_out_last, b_out_valid, b_out_ready = 1'b1;
  logic [33:0]  b_cfg_regs;

  logic [33:0] cfg_mem [16];
  assign cfg_regs   = cfg_mem[sel];
  assign b_cfg_regs = cfg_mem[b_sel];

  always #5 aclk = ~aclk;

  port_inserter #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(2), .TUSER_WIDTH(16)) dut (
    .aclk(aclk), .areset(areset),
    .axis_in_tdata(in_data), .axis_in_tuser(in_user), .axis_in_tid(in_tid), .axis_in_tdest(in_dest),
    .axis_in_tkeep(in_keep), .axis_in_tlast(in_last), .axis_in_tvalid(in_valid), .axis_in_tready(in_ready),
    .axis_out_tdata(out_data), .axis_out_tuser(out_user), .axis_out_tid(out_tid), .axis_out_tdest(out_dest),
    .axis_out_tkeep(out_keep), .axis_out_tlast(out_last), .axis_out_tvalid(out_valid), .axis_out_tready(out_ready),
    .port_config_sel(sel), .port_config_regs(cfg_regs));

  port_inserter #(.AXIS_BUS_WIDTH(512), .AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(0), .TUSER_WIDTH(16)) dut512 (
    .aclk(aclk), .areset(areset),
    .axis_in_tdata(b_in_data), .axis_in_tuser(b_in_user), .axis_in_tid(b_in_tid), .axis_in_tdest(b_in_dest),
    .axis_in_tkeep(b_in_keep), .axis_in_tlast(b_in_last), .axis_in_tvalid(b_in_valid), .axis_in_tready(b_in_ready),
    .axis_out_tdata(b_out_data), .axis_out_tuser(b_out_user), .axis_out_tid(b_out_tid), .axis_out_tdest(b_out_dest),
    .axis_out_tkeep(b_out_keep), .axis_out_tlast(b_out_last), .axis_out_tvalid(b_out_valid), .axis_out_tready(b_out_ready),
    .port_config_sel(b_sel), .port_config_regs(b_cfg_regs));

  typedef struct {
    logic [3:0]  tid;
    logic        tcp, l4v;
    logic [6:0]  off;
    int          len;
    logic [33:0] cfg;
    logic [15:0] s, d, c;
    logic [15:0] es, ed, ec;
  } case_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [15:0] user;
    logic [3:0]  tid;
    logic [1:0]  dest;
  } beat_t;

  case_t tbl [10];
  beat_t q [$];
  int    ncmp = 0, nbad = 0;
  bit    mon_en = 1'b1, rnd = 1'b0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ocsum(input logic [7:0] p [64], input int from, input int to);
    int unsigned s = 0;
    for (int i = from; i < to; i += 2) s += {p[i], p[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  // Random output back-pressure when enabled.
  initial forever begin
    @(posedge aclk); #1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard consumer plus stall-hold check.
  initial begin
    logic [63:0] hold_data = '0;
    bit stalled = 1'b0;
    beat_t e;
    forever begin
      @(negedge aclk);
      if (mon_en) begin
        if (stalled) begin
          chk("hold_valid", 512'(out_valid), 512'(1));
          chk("hold_data", 512'(out_data), 512'(hold_data));
        end
        stalled   = out_valid && !out_ready;
        hold_data = out_data;
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("unexpected_beat", 512'(out_data), 512'(0) - 1);
          else begin
            e = q.pop_front();
            chk("beat", {out_data, out_keep, out_last, out_user, out_tid, out_dest},
                        {e.data, e.keep, e.last, e.user, e.tid, e.dest});
          end
        end
      end else stalled = 1'b0;
    end
  end

  // Drive one table packet; abort stops after 3 beats and expects nothing.
  task automatic send(input int i, input bit abort);
    logic [7:0] pkt [256];
    logic [7:0] exp [256];
    int cp, nb, n;
    beat_t b, e;
    case_t t = tbl[i];
    for (int k = 0; k < 256; k++) pkt[k] = 8'(k * 7 + 3);
    cp = int'(t.off) + (t.tcp ? 16 : 6);
    if (t.off + 1 < t.len) begin pkt[t.off] = t.s[15:8]; pkt[t.off+1] = t.s[7:0]; end
    if (t.off + 3 < t.len) begin pkt[t.off+2] = t.d[15:8]; pkt[t.off+3] = t.d[7:0]; end
    if (cp + 1 < t.len)    begin pkt[cp] = t.c[15:8]; pkt[cp+1] = t.c[7:0]; end
    exp = pkt;
    if (t.off + 1 < t.len) begin exp[t.off] = t.es[15:8]; exp[t.off+1] = t.es[7:0]; end
    if (t.off + 3 < t.len) begin exp[t.off+2] = t.ed[15:8]; exp[t.off+3] = t.ed[7:0]; end
    if (cp + 1 < t.len)    begin exp[cp] = t.ec[15:8]; exp[cp+1] = t.ec[7:0]; end
    nb = (t.len + 7) / 8;
    if (abort) nb = 3;
    for (int j = 0; j < nb; j++) begin
      for (int k = 0; k < 8; k++) begin
        b.data[k*8 +: 8] = pkt[j*8+k];
        e.data[k*8 +: 8] = exp[j*8+k];
        b.keep[k]        = (j*8 + k < t.len);
      end
      b.last = !abort && (j == nb - 1);
      b.user = (j == 0) ? {7'd0, t.l4v, t.tcp, t.off} : 16'($urandom);
      b.tid  = (j == 0) ? t.tid : t.tid ^ 4'hF;
      b.dest = 2'(j);
      e.keep = b.keep; e.last = b.last; e.user = b.user; e.tid = b.tid; e.dest = b.dest;
      if (!abort) q.push_back(e);
      in_data = b.data; in_keep = b.keep; in_last = b.last; in_user = b.user;
      in_tid = b.tid; in_dest = b.dest; in_valid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!in_ready && n < 200);
      if (!in_ready) chk("in_ready_timeout", 512'(in_ready), 512'(1));
      chk("config_sel", 512'(sel), 512'(t.tid));
      @(posedge aclk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 2000) begin @(posedge aclk); n++; end
    #1;
    chk("drain", 512'(q.size()), 512'(0));
  endtask

  initial begin
    logic [7:0] p [64];
    logic [7:0] x [64];
    logic [511:0] bexp;
    logic [15:0] csum;
    //          tid    tcp   l4v   off  len  {sen,den,sport,dport}               s        d        c        es       ed       ec
    tbl[0] = '{4'd1, 1'b0, 1'b1, 7'd34, 64, {1'b1,1'b0,16'h1F90,16'h9999}, 16'h0400, 16'h0035, 16'h1234, 16'h1F90, 16'h0035, 16'hF6A3};
    tbl[1] = '{4'd2, 1'b0, 1'b1, 7'd34, 64, {1'b1,1'b0,16'h1F90,16'h0000}, 16'h0400, 16'h0035, 16'h0000, 16'h1F90, 16'h0035, 16'h0000};
    tbl[2] = '{4'd4, 1'b0, 1'b1, 7'd34, 64, {1'b1,1'b0,16'h1634,16'h0000}, 16'h0400, 16'h0035, 16'h1234, 16'h1634, 16'h0035, 16'hFFFF};
    tbl[3] = '{4'd5, 1'b1, 1'b1, 7'd38, 64, {1'b1,1'b1,16'hC000,16'h1F90}, 16'h0400, 16'h0050, 16'hABCD, 16'hC000, 16'h1F90, 16'hD08C};
    tbl[4] = '{4'd6, 1'b0, 1'b1, 7'd34, 64, {1'b0,1'b0,16'h5555,16'h6666}, 16'h0400, 16'h0035, 16'h1234, 16'h0400, 16'h0035, 16'h1234};
    tbl[5] = '{4'd1, 1'b0, 1'b0, 7'd34, 64, {1'b1,1'b0,16'h1F90,16'h9999}, 16'h0400, 16'h0035, 16'h1234, 16'h0400, 16'h0035, 16'h1234};
    tbl[6] = '{4'd1, 1'b0, 1'b1, 7'd34, 20, {1'b1,1'b0,16'h1F90,16'h9999}, 16'h0400, 16'h0035, 16'h1234, 16'h0400, 16'h0035, 16'h1234};
    tbl[7] = '{4'd8, 1'b0, 1'b1, 7'd34, 64, {1'b0,1'b1,16'h0000,16'h0800}, 16'h1234, 16'h0035, 16'h8000, 16'h1234, 16'h0800, 16'h7835};
    tbl[8] = '{4'd3, 1'b0, 1'b1, 7'd34, 72, {1'b1,1'b1,16'h1111,16'h2222}, 16'h0400, 16'h0035, 16'h1234, 16'h1111, 16'h2222, 16'hE335};
    tbl[9] = '{4'd7, 1'b1, 1'b1, 7'd34, 60, {1'b0,1'b1,16'h0000,16'h0050}, 16'h0400, 16'h01BB, 16'h5555, 16'h0400, 16'h0050, 16'h56C0};
    for (int i = 0; i < 16; i++) cfg_mem[i] = {1'b1, 1'b1, 16'hDEAD, 16'hBEEF};
    for (int i = 0; i < 10; i++) cfg_mem[tbl[i].tid] = tbl[i].cfg;

    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    chk("reset_outs", {out_data, out_keep, out_last, out_user, out_tid, out_dest, out_valid}, '0);
    chk("reset_in_ready", 512'(in_ready), 512'(1));

    for (int i = 0; i < 8; i++) send(i, 1'b0);
    rnd = 1'b1;
    send(8, 1'b0);
    send(9, 1'b0);
    send(8, 1'b0);
    drain();
    rnd = 1'b0;

    // Reset mid-packet: in-flight beat dropped, next packet rewritten from pos 0.
    @(posedge aclk); #1;
    mon_en = 1'b0;
    send(0, 1'b1);
    in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_valid = 1'b1; areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0; in_valid = 1'b0;
    chk("midreset_valid", 512'(out_valid), 512'(0));
    chk("midreset_outs", {out_data, out_keep, out_last, out_user, out_tid, out_dest}, '0);
    @(posedge aclk); #1;
    mon_en = 1'b1;
    send(0, 1'b0);
    send(3, 1'b0);
    drain();

    // 512-bit bus: TCP off 38, S/D/C all in beat 0; C must equal a full recomputation.
    for (int k = 0; k < 64; k++) p[k] = 8'(k * 13 + 5);
    p[38] = 8'h04; p[39] = 8'h00; p[40] = 8'h00; p[41] = 8'h50; p[54] = 8'h00; p[55] = 8'h00;
    csum = ~ocsum(p, 38, 64);
    p[54] = csum[15:8]; p[55] = csum[7:0];
    x = p;
    x[38] = 8'hC0; x[39] = 8'h00; x[40] = 8'h1F; x[41] = 8'h90; x[54] = 8'h00; x[55] = 8'h00;
    csum = ~ocsum(x, 38, 64);
    x[54] = csum[15:8]; x[55] = csum[7:0];
    for (int k = 0; k < 64; k++) begin b_in_data[k*8 +: 8] = p[k]; bexp[k*8 +: 8] = x[k]; end
    b_in_keep = '1; b_in_last = 1'b1; b_in_user = {7'd0, 1'b1, 1'b1, 7'd38}; b_in_tid = 4'd5;
    b_in_valid = 1'b1;
    @(negedge aclk);
    chk("b_in_ready", 512'(b_in_ready), 512'(1));
    @(posedge aclk); #1;
    b_in_valid = 1'b0;
    @(negedge aclk);
    chk("b_out_valid", 512'({b_out_valid, b_out_last}), 512'(3));
    chk("b_out_data", b_out_data, bexp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
